// File: rtl/stream_negate_pkg.sv
// rtl/stream_negate_pkg.sv - shared types for the load-negate-store streaming engine
package stream_negate_pkg;

    // Storage widths of the table/buffer entries; engine parameters must not exceed them.
    localparam int SN_ADDR_W = 64;
    localparam int SN_DATA_W = 64;
    localparam int SN_TAG_W  = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_command_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } engine_state_t;

    // One in-flight load: the tag the memory assigned and the address it was issued to.
    typedef struct packed {
        logic                 valid;
        logic [SN_TAG_W-1:0]  tag;
        logic [SN_ADDR_W-1:0] addr;
    } tag_entry_t;

    // One negated beat waiting to be written back.
    typedef struct packed {
        logic [SN_ADDR_W-1:0] addr;
        logic [SN_DATA_W-1:0] data;
    } store_entry_t;

endpackage

// File: rtl/stream_negate_engine_if.sv
// rtl/stream_negate_engine_if.sv - command/response/tag memory bus between engine and memory
interface stream_negate_engine_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    import stream_negate_pkg::*;

    bus_command_t          proc2mem_command;
    logic [ADDR_WIDTH-1:0] proc2mem_address;
    logic [DATA_WIDTH-1:0] proc2mem_data;
    logic [3:0]            mem2proc_response;
    logic [DATA_WIDTH-1:0] mem2proc_data;
    logic [3:0]            mem2proc_tag;

    modport master (
        output proc2mem_command,
        output proc2mem_address,
        output proc2mem_data,
        input  mem2proc_response,
        input  mem2proc_data,
        input  mem2proc_tag
    );

    modport slave (
        input  proc2mem_command,
        input  proc2mem_address,
        input  proc2mem_data,
        output mem2proc_response,
        output mem2proc_data,
        output mem2proc_tag
    );

endinterface

// File: rtl/stream_negate_lane_array.sv
// rtl/stream_negate_lane_array.sv - per-lane two's-complement negation (NEGATE_SATURATE_EN clamps the most negative lane)
module stream_negate_lane_array #(
    parameter int DATA_WIDTH = 64,
    parameter int INT_WIDTH  = 32
) (
    input  logic [DATA_WIDTH-1:0] lanes_in,
    output logic [DATA_WIDTH-1:0] lanes_out
);

    localparam int NUM_LANES = DATA_WIDTH / INT_WIDTH;

`ifdef NEGATE_SATURATE_EN
    localparam logic [INT_WIDTH-1:0] MOST_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};
    localparam logic [INT_WIDTH-1:0] MOST_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [INT_WIDTH-1:0] lane_in;
        assign lane_in = lanes_in[i*INT_WIDTH +: INT_WIDTH];
`ifdef NEGATE_SATURATE_EN
        // -MIN is not representable; clamp it to MAX instead of wrapping back to MIN.
        assign lanes_out[i*INT_WIDTH +: INT_WIDTH] = (lane_in == MOST_NEG) ? MOST_POS : -lane_in;
`else
        assign lanes_out[i*INT_WIDTH +: INT_WIDTH] = -lane_in;
`endif
    end

endmodule

// File: rtl/stream_negate_engine.sv
// rtl/stream_negate_engine.sv - load-negate-store streaming engine top; optional NEGATE_SATURATE_EN
module stream_negate_engine
    import stream_negate_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int INT_WIDTH       = 32,
    parameter int ADDR_WIDTH      = 64,
    parameter int ADDR_STEP       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STORE_DEPTH     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_beats,
    stream_negate_engine_if.master mem_bus,
    output logic                  busy,
    output logic                  done
);

    localparam int OCC_W = $clog2(STORE_DEPTH + 1);
    localparam int PTR_W = (STORE_DEPTH > 1) ? $clog2(STORE_DEPTH) : 1;
    localparam int TT_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [OCC_W-1:0]      MAX_OUT_C    = OCC_W'(MAX_OUTSTANDING);
    localparam logic [OCC_W:0]        DEPTH_C      = (OCC_W+1)'(STORE_DEPTH);
    localparam logic [PTR_W-1:0]      LAST_PTR_C   = PTR_W'(STORE_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP_C  = ADDR_WIDTH'(ADDR_STEP);

    engine_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] num_beats_q, num_beats_d;
    logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
    logic [ADDR_WIDTH-1:0] loads_issued_q, loads_issued_d;
    logic [ADDR_WIDTH-1:0] stores_accepted_q, stores_accepted_d;
    logic [OCC_W-1:0]      outstanding_q, outstanding_d;
    logic [OCC_W-1:0]      occupancy_q, occupancy_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    tag_entry_t            tag_table_q [MAX_OUTSTANDING];
    tag_entry_t            tag_table_d [MAX_OUTSTANDING];
    store_entry_t          store_buf_q [STORE_DEPTH];
    store_entry_t          store_buf_d [STORE_DEPTH];

    bus_command_t          cmd;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  load_ok;
    logic                  load_accept;
    logic                  store_accept;
    logic                  match_hit;
    logic [TT_W-1:0]       match_idx;
    logic [TT_W-1:0]       free_idx;
    logic [DATA_WIDTH-1:0] negated_data;

    stream_negate_lane_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .INT_WIDTH  (INT_WIDTH)
    ) u_lanes (
        .lanes_in  (mem_bus.mem2proc_data),
        .lanes_out (negated_data)
    );

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR_C) ? '0 : p + PTR_W'(1);
    endfunction

    // Pick the bus command: drain stores first, then issue a load only if its result is guaranteed a buffer slot.
    always_comb begin
        cmd      = BUS_NONE;
        cmd_addr = '0;
        cmd_data = '0;
        load_ok  = (state_q == ST_RUN)
                && (loads_issued_q < num_beats_q)
                && (outstanding_q < MAX_OUT_C)
                && (({1'b0, outstanding_q} + {1'b0, occupancy_q}) < DEPTH_C);
        if (state_q == ST_RUN && occupancy_q != '0) begin
            cmd      = BUS_STORE;
            cmd_addr = store_buf_q[head_q].addr[ADDR_WIDTH-1:0];
            cmd_data = store_buf_q[head_q].data[DATA_WIDTH-1:0];
        end else if (load_ok) begin
            cmd      = BUS_LOAD;
            cmd_addr = load_addr_q;
        end
    end

    assign mem_bus.proc2mem_command = cmd;
    assign mem_bus.proc2mem_address = cmd_addr;
    assign mem_bus.proc2mem_data    = cmd_data;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // Tag-table lookups: slot of the returning tag, and first free slot for a newly accepted load.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!tag_table_q[i].valid) begin
                free_idx = TT_W'(i);
            end
        end
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!match_hit && mem_bus.mem2proc_tag != 4'd0 && tag_table_q[i].valid
                && tag_table_q[i].tag == mem2proc_tag_w()) begin
                match_hit = 1'b1;
                match_idx = TT_W'(i);
            end
        end
    end

    function automatic logic [SN_TAG_W-1:0] mem2proc_tag_w();
        return mem_bus.mem2proc_tag;
    endfunction

    // FSM next state and pass registers latched at start.
    always_comb begin
        state_d     = state_q;
        num_beats_d = num_beats_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_beats_d = num_beats;
                    state_d     = (num_beats == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stores_accepted_q == num_beats_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next state: load issue, load return into the store buffer, store retirement.
    always_comb begin
        load_addr_d       = load_addr_q;
        loads_issued_d    = loads_issued_q;
        stores_accepted_d = stores_accepted_q;
        outstanding_d     = outstanding_q;
        occupancy_d       = occupancy_q;
        head_d            = head_q;
        tail_d            = tail_q;
        tag_table_d       = tag_table_q;
        store_buf_d       = store_buf_q;
        load_accept       = (cmd == BUS_LOAD)  && (mem_bus.mem2proc_response != 4'd0);
        store_accept      = (cmd == BUS_STORE) && (mem_bus.mem2proc_response != 4'd0);

        if (state_q == ST_IDLE && start) begin
            load_addr_d       = base_addr;
            loads_issued_d    = '0;
            stores_accepted_d = '0;
        end

        if (load_accept) begin
            tag_table_d[free_idx].valid = 1'b1;
            tag_table_d[free_idx].tag   = mem_bus.mem2proc_response;
            tag_table_d[free_idx].addr  = SN_ADDR_W'(load_addr_q);
            load_addr_d    = load_addr_q + ADDR_STEP_C;
            loads_issued_d = loads_issued_q + ADDR_WIDTH'(1);
        end

        if (match_hit) begin
            tag_table_d[match_idx].valid = 1'b0;
            store_buf_d[tail_q].addr     = tag_table_q[match_idx].addr;
            store_buf_d[tail_q].data     = SN_DATA_W'(negated_data);
            tail_d = ptr_next(tail_q);
        end

        if (store_accept) begin
            head_d            = ptr_next(head_q);
            stores_accepted_d = stores_accepted_q + ADDR_WIDTH'(1);
        end

        outstanding_d = outstanding_q + OCC_W'(load_accept) - OCC_W'(match_hit);
        occupancy_d   = occupancy_q + OCC_W'(match_hit) - OCC_W'(store_accept);
    end

    // State registers; reset drops any in-flight tags so late returns are ignored.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q           <= ST_IDLE;
            num_beats_q       <= '0;
            load_addr_q       <= '0;
            loads_issued_q    <= '0;
            stores_accepted_q <= '0;
            outstanding_q     <= '0;
            occupancy_q       <= '0;
            head_q            <= '0;
            tail_q            <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_table_q[i] <= '0;
            end
            for (int i = 0; i < STORE_DEPTH; i++) begin
                store_buf_q[i] <= '0;
            end
        end else begin
            state_q           <= state_d;
            num_beats_q       <= num_beats_d;
            load_addr_q       <= load_addr_d;
            loads_issued_q    <= loads_issued_d;
            stores_accepted_q <= stores_accepted_d;
            outstanding_q     <= outstanding_d;
            occupancy_q       <= occupancy_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            tag_table_q       <= tag_table_d;
            store_buf_q       <= store_buf_d;
        end
    end

endmodule

// File: tb/tb_stream_negate_engine.sv
// tb/tb_stream_negate_engine.sv - directed self-checking bench for stream_negate_engine
module tb_stream_negate_engine;
    import stream_negate_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] base_addr = '0;
    logic [63:0] num_beats = '0;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] D1 = 64'h00000005_00000003;
    localparam logic [63:0] E1 = 64'hFFFFFFFB_FFFFFFFD;
    localparam logic [63:0] D2 = 64'h7FFFFFFF_00000000;
    localparam logic [63:0] E2 = 64'h80000001_00000000;
    localparam logic [63:0] D3 = 64'h00000000_00000002;
    localparam logic [63:0] E3 = 64'h00000000_FFFFFFFE;
`ifdef NEGATE_SATURATE_EN
    localparam logic [63:0] E_SAT = 64'h7FFFFFFF_80000001;
`else
    localparam logic [63:0] E_SAT = 64'h80000000_80000001;
`endif

    stream_negate_engine_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) mem_bus ();

    stream_negate_engine #(
        .DATA_WIDTH      (64),
        .INT_WIDTH       (32),
        .ADDR_WIDTH      (64),
        .ADDR_STEP       (4),
        .MAX_OUTSTANDING (4),
        .STORE_DEPTH     (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_beats (num_beats),
        .mem_bus   (mem_bus.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input bus_command_t c, input logic [63:0] a, input logic [63:0] d);
        chk({tag, ".cmd"},  64'(mem_bus.proc2mem_command), 64'(c));
        chk({tag, ".addr"}, mem_bus.proc2mem_address, a);
        chk({tag, ".data"}, mem_bus.proc2mem_data, d);
    endtask

    initial begin
        mem_bus.mem2proc_response = 4'd0;
        mem_bus.mem2proc_tag      = 4'd0;
        mem_bus.mem2proc_data     = '0;

        tick();
        tick();
        chk_bus("reset", BUS_NONE, 64'h0, 64'h0);
        chk("reset.busy", 64'(busy), 64'h0);
        chk("reset.done", 64'(done), 64'h0);
        reset = 1'b1;
        tick();

        // single beat, 3-cycle load latency
        base_addr = 64'h100; num_beats = 64'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1.busy", 64'(busy), 64'h1);
        chk_bus("t1.load", BUS_LOAD, 64'h100, 64'h0);
        mem_bus.mem2proc_response = 4'd1;
        tick();
        mem_bus.mem2proc_response = 4'd0;
        chk_bus("t1.wait", BUS_NONE, 64'h0, 64'h0);
        tick();
        tick();
        mem_bus.mem2proc_tag  = 4'd1;
        mem_bus.mem2proc_data = 64'h00000001_FFFFFFFF;
        chk_bus("t1.ret", BUS_NONE, 64'h0, 64'h0);
        tick();
        mem_bus.mem2proc_tag  = 4'd0;
        mem_bus.mem2proc_data = '0;
        chk_bus("t1.store", BUS_STORE, 64'h100, 64'hFFFFFFFF_00000001);
        mem_bus.mem2proc_response = 4'd2;
        tick();
        mem_bus.mem2proc_response = 4'd0;
        chk_bus("t1.after", BUS_NONE, 64'h0, 64'h0);
        chk("t1.done_early", 64'(done), 64'h0);
        tick();
        chk("t1.done", 64'(done), 64'h1);
        chk("t1.busy_done", 64'(busy), 64'h1);
        tick();
        chk("t1.done_off", 64'(done), 64'h0);
        chk("t1.busy_off", 64'(busy), 64'h0);

        // zero-length pass
        base_addr = 64'h40; num_beats = 64'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t0.done", 64'(done), 64'h1);
        chk_bus("t0.bus", BUS_NONE, 64'h0, 64'h0);
        tick();
        chk("t0.done_off", 64'(done), 64'h0);
        chk("t0.busy_off", 64'(busy), 64'h0);

        // eight beats, memory accepts but holds returns: only four loads go out
        base_addr = 64'h0; num_beats = 64'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_bus($sformatf("t2.load%0d", i), BUS_LOAD, 64'(4 * i), 64'h0);
            mem_bus.mem2proc_response = 4'(i + 1);
            if (i == 0) begin
                start = 1'b1;
                base_addr = 64'h500;
            end
            tick();
            start = 1'b0;
        end
        mem_bus.mem2proc_response = 4'd0;
        chk_bus("t2.limit0", BUS_NONE, 64'h0, 64'h0);
        tick();
        chk_bus("t2.limit1", BUS_NONE, 64'h0, 64'h0);

        // out-of-order returns 3,1,2 plus an unknown tag
        mem_bus.mem2proc_tag = 4'd3; mem_bus.mem2proc_data = D3;
        tick();
        chk_bus("t3.first", BUS_STORE, 64'h8, E3);
        mem_bus.mem2proc_tag = 4'd1; mem_bus.mem2proc_data = D1;
        tick();
        mem_bus.mem2proc_tag = 4'd2; mem_bus.mem2proc_data = D2;
        tick();
        mem_bus.mem2proc_tag = 4'd9; mem_bus.mem2proc_data = 64'hDEAD_BEEF_0000_1111;
        tick();
        mem_bus.mem2proc_tag = 4'd0; mem_bus.mem2proc_data = '0;
        chk_bus("t3.head", BUS_STORE, 64'h8, E3);

        // store refused for five cycles, then drained in return order
        for (int i = 0; i < 5; i++) begin
            chk_bus($sformatf("t4.hold%0d", i), BUS_STORE, 64'h8, E3);
            tick();
        end
        mem_bus.mem2proc_response = 4'd1;
        chk_bus("t4.st0", BUS_STORE, 64'h8, E3);
        tick();
        chk_bus("t4.st1", BUS_STORE, 64'h0, E1);
        tick();
        chk_bus("t4.st2", BUS_STORE, 64'h4, E2);
        tick();
        mem_bus.mem2proc_response = 4'd0;
        chk_bus("t4.reload", BUS_LOAD, 64'h10, 64'h0);
        chk("t4.busy", 64'(busy), 64'h1);

        // reset with two loads outstanding, then late returns
        mem_bus.mem2proc_response = 4'd5;
        tick();
        mem_bus.mem2proc_response = 4'd0;
        chk_bus("t6.pre", BUS_LOAD, 64'h14, 64'h0);
        reset = 1'b0;
        tick();
        chk_bus("t6.rst", BUS_NONE, 64'h0, 64'h0);
        chk("t6.rst_busy", 64'(busy), 64'h0);
        reset = 1'b1;
        mem_bus.mem2proc_tag = 4'd4; mem_bus.mem2proc_data = 64'h1;
        tick();
        mem_bus.mem2proc_tag = 4'd5; mem_bus.mem2proc_data = 64'h2;
        tick();
        mem_bus.mem2proc_tag = 4'd0; mem_bus.mem2proc_data = '0;
        chk_bus("t6.late0", BUS_NONE, 64'h0, 64'h0);
        chk("t6.busy", 64'(busy), 64'h0);
        chk("t6.done", 64'(done), 64'h0);
        tick();
        chk_bus("t6.late1", BUS_NONE, 64'h0, 64'h0);

        // most-negative lane
        base_addr = 64'h200; num_beats = 64'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_bus("t5.load", BUS_LOAD, 64'h200, 64'h0);
        mem_bus.mem2proc_response = 4'd7;
        tick();
        mem_bus.mem2proc_response = 4'd0;
        mem_bus.mem2proc_tag = 4'd7; mem_bus.mem2proc_data = 64'h80000000_7FFFFFFF;
        tick();
        mem_bus.mem2proc_tag = 4'd0; mem_bus.mem2proc_data = '0;
        chk_bus("t5.store", BUS_STORE, 64'h200, E_SAT);
        mem_bus.mem2proc_response = 4'd1;
        tick();
        mem_bus.mem2proc_response = 4'd0;
        tick();
        chk("t5.done", 64'(done), 64'h1);
        tick();
        chk("t5.busy_off", 64'(busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
